// File: rtl/dw_arb_pkg.sv
// Shared constants and helpers for the dynamic-priority arbiter family.
package dw_arb_pkg;

  localparam int PARK_NONE  = 0;
  localparam int PARK_FIXED = 1;

  // Smallest r with 2**r >= n; used to size index fields from a client count.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dw_arb_rr_pick.sv
// Rotating priority encoder: first set bit of cand at or above ptr, with wrap.
module dw_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the closest candidate to ptr wins.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (cand[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dw_arb_dp_age.sv
// Dynamic-priority arbiter with aging, round-robin tie-break, lock, mask and park.
module dw_arb_dp_age
  import dw_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int PW         = 2,
  parameter int AGE_W      = 2,
  parameter int PARK_MODE  = PARK_FIXED,
  parameter int PARK_INDEX = 0,
  parameter int IW         = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [N-1:0]    request,
  input  logic [N*PW-1:0] prior,
  input  logic [N-1:0]    lock,
  input  logic [N-1:0]    mask,
  output logic            parked,
  output logic            granted,
  output logic            locked,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_index
);

  localparam logic [AGE_W-1:0] AGE_MAX    = '1;
  localparam logic             PARK_FLAG  = (PARK_MODE == PARK_FIXED);
  localparam logic [N-1:0]     PARK_GRANT = PARK_FLAG ? (N'(1) << PARK_INDEX) : '0;
  localparam logic [IW-1:0]    PARK_IDX   = PARK_FLAG ? IW'(PARK_INDEX) : '0;

  logic [AGE_W-1:0] age [N];
  logic [IW-1:0]    rr_ptr;

  logic [N-1:0]  eligible;
  logic [N-1:0]  urgent;
  logic [N-1:0]  cand_min;
  logic [PW-1:0] min_p;
  logic          urg_found, min_found;
  logic [IW-1:0] urg_idx, min_idx;
  logic          lock_hold, pick_valid, win_valid;
  logic [IW-1:0] pick_idx, win_idx;

  // Eligibility, starvation flags and the minimum-priority candidate set.
  always_comb begin
    eligible = request & ~mask;
    urgent   = '0;
    cand_min = '0;
    min_p    = '1;
    for (int i = 0; i < N; i++) begin
      urgent[i] = eligible[i] && (age[i] == AGE_MAX);
      if (eligible[i] && (prior[i*PW +: PW] < min_p)) min_p = prior[i*PW +: PW];
    end
    for (int i = 0; i < N; i++) begin
      cand_min[i] = eligible[i] && (prior[i*PW +: PW] == min_p);
    end
  end

  dw_arb_rr_pick #(.N(N), .IW(IW)) u_pick_urgent (
    .cand  (urgent),
    .ptr   (rr_ptr),
    .found (urg_found),
    .idx   (urg_idx)
  );

  dw_arb_rr_pick #(.N(N), .IW(IW)) u_pick_min (
    .cand  (cand_min),
    .ptr   (rr_ptr),
    .found (min_found),
    .idx   (min_idx)
  );

  // Winner selection: a held lock beats aging, aging beats priority.
  always_comb begin
    lock_hold  = granted && lock[grant_index];
    pick_valid = urg_found || min_found;
    pick_idx   = urg_found ? urg_idx : min_idx;
    win_valid  = lock_hold || pick_valid;
    win_idx    = lock_hold ? grant_index : pick_idx;
  end

  // Registered grant outputs and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= PARK_GRANT;
      grant_index <= PARK_IDX;
      parked      <= PARK_FLAG;
      granted     <= 1'b0;
      locked      <= 1'b0;
      rr_ptr      <= '0;
    end else if (!enable) begin
      grant       <= '0;
      grant_index <= '0;
      parked      <= 1'b0;
      granted     <= 1'b0;
      locked      <= 1'b0;
    end else if (win_valid) begin
      grant       <= N'(1) << win_idx;
      grant_index <= win_idx;
      parked      <= 1'b0;
      granted     <= 1'b1;
      locked      <= lock_hold;
      if (!lock_hold) rr_ptr <= (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
    end else begin
      grant       <= PARK_GRANT;
      grant_index <= PARK_IDX;
      parked      <= PARK_FLAG;
      granted     <= 1'b0;
      locked      <= 1'b0;
    end
  end

  // Age counters: waiting eligible clients saturate upward, everyone else clears.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        age[i] <= '0;
      end else if (enable) begin
        if (eligible[i] && !(win_valid && (win_idx == IW'(i))))
          age[i] <= (age[i] == AGE_MAX) ? age[i] : age[i] + AGE_W'(1);
        else
          age[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dw_arb_dp_age.sv
// Bench for dw_arb_dp_age: directed scenarios then random traffic, all
// compared every cycle against a behavioural model of the arbitration rules.
module tb_dw_arb_dp_age;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int AMAX = 3;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [3:0] request, lock, mask;
  logic [7:0] prior;
  logic       parked, granted, locked;
  logic [3:0] grant;
  logic [1:0] grant_index;

  int checks = 0;
  int failures = 0;

  int         m_age [4];
  int         m_ptr;
  int         m_gidx;
  bit         m_granted, m_locked, m_parked;
  logic [3:0] m_grant;

  dw_arb_dp_age #(
    .N(N), .PW(PW), .AGE_W(2), .PARK_MODE(1), .PARK_INDEX(0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .request     (request),
    .prior       (prior),
    .lock        (lock),
    .mask        (mask),
    .parked      (parked),
    .granted     (granted),
    .locked      (locked),
    .grant       (grant),
    .grant_index (grant_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int prio(input int i);
    return int'(prior[i*PW +: PW]);
  endfunction

  // Reference: apply the arbitration rules directly to the sampled inputs.
  task automatic model_step();
    int  w;
    int  best;
    int  j;
    bit  hold;
    bit  elig [4];
    if (rst) begin
      foreach (m_age[i]) m_age[i] = 0;
      m_ptr = 0; m_granted = 0; m_locked = 0;
      m_parked = 1; m_gidx = 0; m_grant = 4'b0001;
    end else if (!enable) begin
      m_granted = 0; m_locked = 0; m_parked = 0; m_gidx = 0; m_grant = 4'b0000;
    end else begin
      w = -1;
      hold = m_granted && lock[2'(m_gidx)];
      for (int i = 0; i < 4; i++) elig[i] = request[i] && !mask[i];
      if (hold) begin
        w = m_gidx;
      end else begin
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (w < 0 && elig[j] && m_age[j] == AMAX) w = j;
        end
        if (w < 0) begin
          best = 99;
          for (int i = 0; i < 4; i++) if (elig[i] && prio(i) < best) best = prio(i);
          for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (w < 0 && elig[j] && prio(j) == best) w = j;
          end
        end
        if (w >= 0) m_ptr = (w + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        m_age[i] = (i == w || !elig[i]) ? 0 : ((m_age[i] < AMAX) ? m_age[i] + 1 : AMAX);
      if (w >= 0) begin
        m_grant = 4'(1 << w); m_gidx = w; m_granted = 1; m_parked = 0; m_locked = hold;
      end else begin
        m_grant = 4'b0001; m_gidx = 0; m_granted = 0; m_parked = 1; m_locked = 0;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("grant",       32'(grant),       32'(m_grant));
    check("grant_index", 32'(grant_index), 32'(m_gidx));
    check("parked",      32'(parked),      32'(m_parked));
    check("granted",     32'(granted),     32'(m_granted));
    check("locked",      32'(locked),      32'(m_locked));
    check("onehot0",     32'($onehot0(grant)), 32'h1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] seq_age [5];
    logic [3:0] seq_rr  [5];
    seq_age = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
    seq_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1; enable = 1'b1; request = '0; prior = '0; lock = '0; mask = '0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_grant",   32'(grant),       32'h1);
    check("rst_index",   32'(grant_index), 32'h0);
    check("rst_parked",  32'(parked),      32'h1);
    check("rst_granted", 32'(granted),     32'h0);
    check("rst_locked",  32'(locked),      32'h0);

    request = 4'b1111;
    prior   = {2'd3, 2'd0, 2'd3, 2'd3};
    cycle();
    check("prio_grant", 32'(grant),       32'h4);
    check("prio_index", 32'(grant_index), 32'h2);

    pulse_reset();
    request = 4'b0011;
    prior   = {2'd0, 2'd0, 2'd0, 2'd3};
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("age_seq", 32'(grant), 32'(seq_age[i]));
    end

    pulse_reset();
    request = 4'b1111;
    prior   = {2'd1, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_seq", 32'(grant), 32'(seq_rr[i]));
    end

    pulse_reset();
    request = 4'b0010;
    prior   = {2'd0, 2'd3, 2'd0, 2'd3};
    cycle();
    check("lock_first", 32'(grant), 32'h2);
    request = 4'b1010;
    lock    = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("lock_hold_grant", 32'(grant),  32'h2);
      check("lock_hold_flag",  32'(locked), 32'h1);
    end
    lock = 4'b0000;
    cycle();
    check("lock_release_grant", 32'(grant),  32'h8);
    check("lock_release_flag",  32'(locked), 32'h0);

    request = 4'b1111;
    mask    = 4'b1111;
    cycle();
    check("mask_grant",  32'(grant),  32'h1);
    check("mask_parked", 32'(parked), 32'h1);
    mask  = 4'b0000;
    prior = {2'd1, 2'd1, 2'd1, 2'd1};
    cycle();
    check("pre_disable_grant", 32'(grant), 32'h1);
    enable = 1'b0;
    cycle();
    cycle();
    check("dis_grant",   32'(grant),   32'h0);
    check("dis_parked",  32'(parked),  32'h0);
    check("dis_granted", 32'(granted), 32'h0);
    enable = 1'b1;
    cycle();
    check("resume_grant", 32'(grant), 32'h2);

    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 39) == 0);
      enable  = ($urandom_range(0, 9) != 0);
      request = 4'($urandom);
      prior   = 8'($urandom);
      lock    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
